// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported, byte-addressed 32-bit data memory between the core
// load/store unit (port 0) and the accelerator DMA engine (port 1). One access
// is granted per cycle using round-robin arbitration. A port can hold ownership
// across an atomic sequence with its lock input, and a timeout of LOCK_MAX
// cycles bounds that ownership. Read data from the memory arrives one cycle
// after the grant and is steered back to the issuing port. Accesses beyond the
// end of memory are granted but never reach the memory; they answer with an
// error pulse, plus a zero read response for reads.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req0/1, we0/1, lock0/1     per-port request, write enable, lock hold
//   addr0/1, wdata0/1          per-port byte address and write data
//   gnt0/1                     combinational grant for the current cycle
//   rvalid0/1, rdata0/1        read response (rdata holds while rvalid=0)
//   err0/1                     one-cycle pulse for an out-of-range access
//   mem_address, mem_write_data, mem_write, mem_read   memory request side
//   mem_read_data              memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned     CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [31:0]     ADDR_MAX = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_grant_q, last_grant_d;

    logic              rvalid0_q, rvalid1_q;
    logic              err0_q, err1_q;
    logic [31:0]       rdata0_q, rdata1_q;
    logic              rpend_q;     // an in-range read is returning this cycle
    logic              rtag_q;      // port that issued that read

    logic              g0, g1, gnt_any, sel1;
    logic [31:0]       a_addr, a_wdata;
    logic              a_we, a_lock, in_range;

    // Grant selection. Reset suppresses all grants in the reset cycle.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        // Tie goes to the port that did not win last time.
                        if (last_grant_q) g0 = 1'b1;
                        else              g1 = 1'b1;
                    end else begin
                        g0 = req0;
                        g1 = req1;
                    end
                end
                LOCK0:   g0 = req0;
                LOCK1:   g1 = req1;
                default: ;
            endcase
        end
    end

    assign gnt0    = g0;
    assign gnt1    = g1;
    assign gnt_any = g0 | g1;
    assign sel1    = g1;

    assign a_addr   = sel1 ? addr1  : addr0;
    assign a_wdata  = sel1 ? wdata1 : wdata0;
    assign a_we     = sel1 ? we1    : we0;
    assign a_lock   = sel1 ? lock1  : lock0;
    assign in_range = (a_addr <= ADDR_MAX);

    assign mem_address    = gnt_any ? a_addr  : '0;
    assign mem_write_data = gnt_any ? a_wdata : '0;
    assign mem_write      = gnt_any &&  a_we && in_range;
    assign mem_read       = gnt_any && !a_we && in_range;

    // Lock FSM next state.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt_any) last_grant_d = sel1;
        unique case (state_q)
            IDLE: begin
                if (gnt_any && a_lock) begin
                    state_d    = sel1 ? LOCK1 : LOCK0;
                    lock_cnt_d = '0;
                end
            end
            LOCK0: begin
                // In LOCK0 a request from port 0 is always granted, so both
                // release conditions (granted with lock0=0, or idle with
                // lock0=0) reduce to lock0 being low.
                if (lock_cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    lock_cnt_d   = '0;
                    last_grant_d = 1'b0;
                end else if (!lock0) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCK1: begin
                if (lock_cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    lock_cnt_d   = '0;
                    last_grant_d = 1'b1;
                end else if (!lock1) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rpend_q      <= 1'b0;
            rtag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rvalid0_q    <= g0 && !a_we;
            rvalid1_q    <= g1 && !a_we;
            err0_q       <= g0 && !in_range;
            err1_q       <= g1 && !in_range;
            rpend_q      <= mem_read;
            rtag_q       <= sel1;
            // Hold registers capture the value shown during the rvalid cycle
            // so rdata stays stable afterwards; an out-of-range read shows 0.
            if (g0 && !a_we && !in_range)  rdata0_q <= '0;
            else if (rpend_q && !rtag_q)   rdata0_q <= mem_read_data;
            if (g1 && !a_we && !in_range)  rdata1_q <= '0;
            else if (rpend_q && rtag_q)    rdata1_q <= mem_read_data;
        end
    end

    // Memory data is only available during the return cycle, so the response
    // passes it through directly and the hold register covers later cycles.
    // Responses are masked while reset is asserted.
    assign rvalid0 = rvalid0_q && !rst;
    assign rvalid1 = rvalid1_q && !rst;
    assign err0    = err0_q && !rst;
    assign err1    = err1_q && !rst;
    assign rdata0  = (rpend_q && !rtag_q && !rst) ? mem_read_data : rdata0_q;
    assign rdata1  = (rpend_q &&  rtag_q && !rst) ? mem_read_data : rdata1_q;

endmodule
